mem_arbiter: RTL and testbench

Shares the single tagged unified-memory port between the 2-wide fetch stage (instruction requester) and the load/store unit (data requester). Each cycle it picks one requester, drives the memory command, and records which requester owns each accepted load tag. It routes returning tagged data back to the owner and discards fetch returns made stale by a branch redirect. It sits between if_mod / LSU and the memory model.

---
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates fetch and LSU onto the tagged memory port and routes tagged returns to their owner.
module mem_arbiter #(
    parameter int TAG_W        = 4,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_IF_OUT   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req_valid,
    input  logic [63:0]       if_req_addr,
    output logic              if_grant,
    output logic              if_resp_valid,
    output logic [63:0]       if_resp_data,
    input  logic              dm_req_valid,
    input  logic [1:0]        dm_req_cmd,
    input  logic [63:0]       dm_req_addr,
    input  logic [63:0]       dm_req_data,
    output logic              dm_grant,
    output logic              dm_resp_valid,
    output logic [63:0]       dm_resp_data,
    input  logic              flush,
    output logic [1:0]        proc2mem_command,
    output logic [63:0]       proc2mem_addr,
    output logic [63:0]       proc2mem_data,
    input  logic [TAG_W-1:0]  mem2proc_response,
    input  logic [63:0]       mem2proc_data,
    input  logic [TAG_W-1:0]  mem2proc_tag,
    output logic              err_tag
);

    localparam int NTAG = 2 ** TAG_W;
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam int CNT_W = $clog2(MAX_IF_OUT + 1);
    localparam logic [SC_W-1:0]  SC_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] IF_MAX = CNT_W'(MAX_IF_OUT);

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_LOAD = 2'b01;

    typedef enum logic [1:0] {
        O_FREE  = 2'd0,
        O_FETCH = 2'd1,
        O_DATA  = 2'd2,
        O_STALE = 2'd3
    } owner_e;

    // Entry 0 is never written: tag 0 means "no tag".
    owner_e owner_q [NTAG];
    owner_e owner_d [NTAG];

    logic [SC_W-1:0]  starve_cnt, starve_d;
    logic [CNT_W-1:0] if_out_cnt, if_out_d;
    logic             err_d;

    logic   fetch_elig, fetch_win, data_win, accepted;
    logic   ret_valid, load_acc, cnt_inc, cnt_dec;
    owner_e ret_owner;

    always_comb begin
        fetch_elig = if_req_valid & ~flush & (if_out_cnt < IF_MAX);
        fetch_win  = fetch_elig & (~dm_req_valid | (starve_cnt == SC_MAX));
        data_win   = dm_req_valid & ~fetch_win;
        accepted   = (mem2proc_response != '0);
        ret_valid  = (mem2proc_tag != '0);
        ret_owner  = owner_q[mem2proc_tag];
    end

    // Every output is gated by reset so an asynchronous reset silences the port immediately.
    always_comb begin
        proc2mem_command = CMD_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if_grant         = 1'b0;
        dm_grant         = 1'b0;
        if_resp_valid    = 1'b0;
        if_resp_data     = '0;
        dm_resp_valid    = 1'b0;
        dm_resp_data     = '0;
        if (reset) begin
            if (fetch_win) begin
                proc2mem_command = CMD_LOAD;
                proc2mem_addr    = if_req_addr;
                if_grant         = accepted;
            end else if (data_win) begin
                proc2mem_command = dm_req_cmd;
                proc2mem_addr    = dm_req_addr;
                proc2mem_data    = dm_req_data;
                dm_grant         = accepted;
            end
            // A fetch return racing a flush is already stale.
            if (ret_valid && ret_owner == O_FETCH && !flush) begin
                if_resp_valid = 1'b1;
                if_resp_data  = mem2proc_data;
            end
            if (ret_valid && ret_owner == O_DATA) begin
                dm_resp_valid = 1'b1;
                dm_resp_data  = mem2proc_data;
            end
        end
    end

    always_comb begin
        load_acc = dm_grant & (dm_req_cmd == CMD_LOAD);
        cnt_inc  = if_grant;
        cnt_dec  = ret_valid & ((ret_owner == O_FETCH) | (ret_owner == O_STALE));
        if_out_d = if_out_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
        err_d    = err_tag | (ret_valid & (ret_owner == O_FREE));

        starve_d = starve_cnt;
        if (!fetch_elig || if_grant) begin
            starve_d = '0;
        end else if (data_win && starve_cnt != SC_MAX) begin
            starve_d = starve_cnt + 1'b1;
        end

        // Return clears the old owner before a same-cycle accept claims the tag.
        owner_d = owner_q;
        for (int i = 0; i < NTAG; i++) begin
            if (flush && owner_q[i] == O_FETCH) begin
                owner_d[i] = O_STALE;
            end
        end
        if (ret_valid) begin
            owner_d[mem2proc_tag] = O_FREE;
        end
        if (if_grant) begin
            owner_d[mem2proc_response] = O_FETCH;
        end else if (load_acc) begin
            owner_d[mem2proc_response] = O_DATA;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NTAG; i++) begin
                owner_q[i] <= O_FREE;
            end
            starve_cnt <= '0;
            if_out_cnt <= '0;
            err_tag    <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            starve_cnt <= starve_d;
            if_out_cnt <= if_out_d;
            err_tag    <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a tag-ownership model.
module tb_mem_arbiter;

    localparam int SL  = 4;
    localparam int MIO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req_valid;
    logic [63:0] if_req_addr;
    logic        if_grant, if_resp_valid;
    logic [63:0] if_resp_data;
    logic        dm_req_valid;
    logic [1:0]  dm_req_cmd;
    logic [63:0] dm_req_addr, dm_req_data;
    logic        dm_grant, dm_resp_valid;
    logic [63:0] dm_resp_data;
    logic        flush;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr, proc2mem_data;
    logic [3:0]  mem2proc_response, mem2proc_tag;
    logic [63:0] mem2proc_data;
    logic        err_tag;

    mem_arbiter #(.TAG_W(4), .STARVE_LIMIT(SL), .MAX_IF_OUT(MIO)) dut (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_grant(if_grant),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .dm_req_valid(dm_req_valid), .dm_req_cmd(dm_req_cmd), .dm_req_addr(dm_req_addr),
        .dm_req_data(dm_req_data), .dm_grant(dm_grant), .dm_resp_valid(dm_resp_valid),
        .dm_resp_data(dm_resp_data), .flush(flush),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
        .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag), .err_tag(err_tag)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: who owns each tag (0 free, 1 fetch, 2 data, 3 stale), fetches outstanding, lost rounds.
    int m_owner [16];
    int m_ifout;
    int m_starve;
    bit m_err;
    bit c_fe, c_fw, c_dw, c_acc;
    int c_st;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_owner[i]) m_owner[i] = 0;
        m_ifout  = 0;
        m_starve = 0;
        m_err    = 0;
    endtask

    task automatic drive_idle();
        if_req_valid = 0; if_req_addr = '0;
        dm_req_valid = 0; dm_req_cmd = 2'b00; dm_req_addr = '0; dm_req_data = '0;
        flush = 0; mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
    endtask

    task automatic settle();
        logic [63:0] e_cmd, e_addr, e_data;
        #1;
        c_fe  = if_req_valid && !flush && (m_ifout < MIO);
        c_fw  = c_fe && (!dm_req_valid || m_starve == SL);
        c_dw  = dm_req_valid && !c_fw;
        c_acc = (mem2proc_response != 0);
        c_st  = (mem2proc_tag != 0) ? m_owner[mem2proc_tag] : -1;
        e_cmd  = c_fw ? 64'd1 : (c_dw ? {62'd0, dm_req_cmd} : 64'd0);
        e_addr = c_fw ? if_req_addr : (c_dw ? dm_req_addr : 64'd0);
        e_data = c_dw ? dm_req_data : 64'd0;
        check("cmd", {62'd0, proc2mem_command}, e_cmd);
        check("addr", proc2mem_addr, e_addr);
        check("wdata", proc2mem_data, e_data);
        check("if_grant", {63'd0, if_grant}, {63'd0, c_fw && c_acc});
        check("dm_grant", {63'd0, dm_grant}, {63'd0, c_dw && c_acc});
        check("if_resp_valid", {63'd0, if_resp_valid}, {63'd0, c_st == 1 && !flush});
        check("if_resp_data", if_resp_data, (c_st == 1 && !flush) ? mem2proc_data : 64'd0);
        check("dm_resp_valid", {63'd0, dm_resp_valid}, {63'd0, c_st == 2});
        check("dm_resp_data", dm_resp_data, (c_st == 2) ? mem2proc_data : 64'd0);
        check("err_tag", {63'd0, err_tag}, {63'd0, m_err});
    endtask

    task automatic advance();
        @(posedge clock);
        if (c_st == 0) m_err = 1;
        if (c_st >= 0) begin
            if (c_st == 1 || c_st == 3) m_ifout--;
            m_owner[mem2proc_tag] = 0;
        end
        if (flush) foreach (m_owner[i]) if (m_owner[i] == 1) m_owner[i] = 3;
        if (c_fw && c_acc) begin
            m_owner[mem2proc_response] = 1;
            m_ifout++;
        end else if (c_dw && c_acc && dm_req_cmd == 2'b01) begin
            m_owner[mem2proc_response] = 2;
        end
        if (!c_fe || (c_fw && c_acc)) m_starve = 0;
        else if (c_dw && m_starve < SL) m_starve++;
        @(negedge clock);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    // Asserts reset mid-cycle with live inputs; outputs must drop before the next edge.
    task automatic async_reset();
        #2 reset = 0;
        #1;
        check("rst_cmd", {62'd0, proc2mem_command}, 64'd0);
        check("rst_grants", {62'd0, if_grant, dm_grant}, 64'd0);
        check("rst_valids", {62'd0, if_resp_valid, dm_resp_valid}, 64'd0);
        check("rst_rdata", if_resp_data | dm_resp_data, 64'd0);
        check("rst_err", {63'd0, err_tag}, 64'd0);
        model_reset();
        @(negedge clock);
        drive_idle();
        @(negedge clock);
        reset = 1;
    endtask

    task automatic random_inputs();
        int busy [$];
        int t;
        drive_idle();
        if_req_valid = ($urandom_range(0, 3) != 0);
        if_req_addr  = {$urandom, $urandom} & ~64'h7;
        dm_req_valid = ($urandom_range(0, 2) != 0);
        dm_req_cmd   = $urandom_range(0, 1) ? 2'b01 : 2'b10;
        dm_req_addr  = {$urandom, $urandom};
        dm_req_data  = {$urandom, $urandom};
        flush        = ($urandom_range(0, 9) == 0);
        mem2proc_data = {$urandom, $urandom};
        foreach (m_owner[i]) if (i != 0 && m_owner[i] != 0) busy.push_back(i);
        if (busy.size() != 0 && $urandom_range(0, 1) == 1)
            mem2proc_tag = 4'(busy[$urandom_range(0, busy.size() - 1)]);
        else if ($urandom_range(0, 15) == 0)
            mem2proc_tag = 4'($urandom_range(1, 15));
        if ($urandom_range(0, 4) != 0) begin
            for (int k = 0; k < 4; k++) begin
                t = $urandom_range(1, 15);
                if (m_owner[t] == 0 || t == int'(mem2proc_tag)) begin
                    mem2proc_response = 4'(t);
                    break;
                end
            end
        end
    endtask

    initial begin
        drive_idle();
        model_reset();
        @(negedge clock);
        settle();
        @(negedge clock);
        reset = 1;

        // Single fetch, tag 3, returned next cycle.
        if_req_valid = 1; mem2proc_response = 4'd3;
        settle();
        check("t1_grant", {63'd0, if_grant}, 64'd1);
        check("t1_cmd", {62'd0, proc2mem_command}, 64'd1);
        advance();
        drive_idle();
        mem2proc_tag = 4'd3; mem2proc_data = 64'h0123456789abcdef;
        settle();
        check("t1_resp", if_resp_data, 64'h0123456789abcdef);
        advance();

        // Both requesting: DATA x4 then FETCH.
        for (int i = 0; i < 10; i++) begin
            drive_idle();
            if_req_valid = 1; dm_req_valid = 1; dm_req_cmd = 2'b10;
            mem2proc_response = 4'(i + 1);
            settle();
            check("starve_pat", {63'd0, if_grant}, {63'd0, i % 5 == 4});
            advance();
        end
        for (int i = 5; i <= 10; i += 5) begin
            drive_idle(); mem2proc_tag = 4'(i); step();
        end

        // Four fetches outstanding: fifth is blocked, store gets the port.
        for (int i = 1; i <= 4; i++) begin
            drive_idle(); if_req_valid = 1; mem2proc_response = 4'(i); step();
        end
        drive_idle();
        if_req_valid = 1; dm_req_valid = 1; dm_req_cmd = 2'b10; mem2proc_response = 4'd6;
        settle();
        check("full_cmd", {62'd0, proc2mem_command}, 64'd2);
        check("full_dmg", {63'd0, dm_grant}, 64'd1);
        advance();
        for (int i = 1; i <= 4; i++) begin
            drive_idle(); mem2proc_tag = 4'(i); step();
        end

        // Fetch on tag 5 made stale by a flush.
        drive_idle(); if_req_valid = 1; mem2proc_response = 4'd5; step();
        drive_idle(); flush = 1; step();
        drive_idle(); step();
        drive_idle(); mem2proc_tag = 4'd5; mem2proc_data = 64'hdead;
        settle();
        check("stale_drop", {63'd0, if_resp_valid}, 64'd0);
        advance();
        drive_idle(); settle();
        check("stale_err", {63'd0, err_tag}, 64'd0);
        advance();

        // Tag 2 returns for a fetch while a load is accepted on tag 2.
        drive_idle(); if_req_valid = 1; mem2proc_response = 4'd2; step();
        drive_idle();
        dm_req_valid = 1; dm_req_cmd = 2'b01; mem2proc_response = 4'd2;
        mem2proc_tag = 4'd2; mem2proc_data = 64'h1111;
        settle();
        check("reuse_if", {63'd0, if_resp_valid}, 64'd1);
        advance();
        drive_idle(); mem2proc_tag = 4'd2; mem2proc_data = 64'h2222;
        settle();
        check("reuse_dm", {63'd0, dm_resp_valid}, 64'd1);
        advance();

        // Return on an unowned tag sets sticky err_tag.
        drive_idle(); mem2proc_tag = 4'd7; step();
        drive_idle(); step();
        drive_idle(); settle();
        check("err_sticky", {63'd0, err_tag}, 64'd1);
        if_req_valid = 1; mem2proc_response = 4'd3; mem2proc_tag = 4'd7;
        async_reset();

        for (int n = 0; n < 3000; n++) begin
            random_inputs();
            if (n % 700 == 699) async_reset();
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
